// File: rtl/systolic_feeder_pkg.sv
// Shared constants, FSM encoding and helpers for the systolic array feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package params;

    localparam int SA_DIM = 8;
    localparam int DW     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } feed_state_t;

    // Saturating increment for the 16-bit beat counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One skew lane: a DEPTH-stage register chain carrying {en, cm, data}.
// Latency: DEPTH cycles from data_in to data_out.
// Backpressure: none; shifts every cycle, clr wipes all stages synchronously.
module skew_lane #(
    parameter int DEPTH = 1,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en_in,
    input  logic          cm_in,
    input  logic [DW-1:0] data_in,
    output logic          en_out,
    output logic          cm_out,
    output logic [DW-1:0] data_out
);

    logic [DW+1:0] stg [DEPTH];

    // Shift the {en, cm, data} word one stage per cycle; clr empties the lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) stg[s] <= '0;
        end else if (clr) begin
            for (int s = 0; s < DEPTH; s++) stg[s] <= '0;
        end else begin
            stg[0] <= {en_in, cm_in, data_in};
            for (int s = 1; s < DEPTH; s++) stg[s] <= stg[s-1];
        end
    end

    assign {en_out, cm_out, data_out} = stg[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews A columns / B rows into a DIMxDIM systolic array; lane i delays by i+1.
// Latency: beat accepted at t appears on lane i at t+1+i; done at t_last+DIM.
// Backpressure: in_ready drops for DIM drain cycles after the last beat and while abort is high.
module systolic_feeder #(
    parameter int DIM = params::SA_DIM,
    parameter int DW  = params::DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [DIM-1:0][DW-1:0] a_col,
    input  logic [DIM-1:0][DW-1:0] b_row,
    input  logic                   abort,
    output logic [DIM-1:0][DW-1:0] aleft,
    output logic [DIM-1:0]         enleft,
    output logic [DIM-1:0]         cmleft,
    output logic [DIM-1:0][DW-1:0] bup,
    output logic [DIM-1:0]         enup,
    output logic [DIM-1:0]         cmup,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            beat_cnt
);

    import params::*;

    localparam int CW = $clog2(DIM + 1) + 1;

    feed_state_t   state;
    logic [CW-1:0] drain_cnt;
    logic          accept;
    logic          inj_cm;

    assign in_ready = !abort && (state != DRAIN);
    assign accept   = in_valid && in_ready;
    assign inj_cm   = accept && in_last;
    assign busy     = (state != IDLE);

    // Tile sequencing: beat counting, drain countdown and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                drain_cnt <= '0;
            end else begin
                case (state)
                    IDLE, FEED: begin
                        if (accept) begin
                            beat_cnt <= (state == IDLE) ? 16'd1 : sat_inc16(beat_cnt);
                            if (in_last) begin
                                state     <= DRAIN;
                                drain_cnt <= CW'(DIM);
                                // a one-deep array shows the last beat in the very first drain cycle
                                done      <= (DIM == 1);
                            end else begin
                                state <= FEED;
                            end
                        end
                    end
                    DRAIN: begin
                        drain_cnt <= drain_cnt - 1'b1;
                        // registered so it lines up with the last beat on lane DIM-1
                        done      <= (drain_cnt == CW'(2));
                        if (drain_cnt == CW'(1)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        skew_lane #(.DEPTH(i + 1), .DW(DW)) u_a (
            .clk      (clk),
            .rst      (rst),
            .clr      (abort),
            .en_in    (accept),
            .cm_in    (inj_cm),
            .data_in  (accept ? a_col[i] : '0),
            .en_out   (enleft[i]),
            .cm_out   (cmleft[i]),
            .data_out (aleft[i])
        );
        skew_lane #(.DEPTH(i + 1), .DW(DW)) u_b (
            .clk      (clk),
            .rst      (rst),
            .clr      (abort),
            .en_in    (accept),
            .cm_in    (inj_cm),
            .data_in  (accept ? b_row[i] : '0),
            .en_out   (enup[i]),
            .cm_out   (cmup[i]),
            .data_out (bup[i])
        );
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter DIM, default params::SA_DIM (8); lanes per operand and skew depth.
REQ-002 Parameter DW, default params::DW (32); element width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  feeder accepts a beat this cycle.
REQ-007 in_last  input  1  accepted beat is the final k-step of the tile.
REQ-008 a_col  input  DIM x DW  column k of A; element i targets array row i.
REQ-009 b_row  input  DIM x DW  row k of B; element j targets array column j.
REQ-010 abort  input  1  synchronous flush of all feeder state.
REQ-011 aleft / enleft / cmleft  output  DIM x DW / DIM / DIM  skewed row-side data, enable and commit flag to the array.
REQ-012 bup / enup / cmup  output  DIM x DW / DIM / DIM  skewed column-side data, enable and commit flag to the array.
REQ-013 busy  output  1  high in FEED or DRAIN.
REQ-014 done  output  1  one-cycle pulse when the last skewed lane has been presented.
REQ-015 beat_cnt  output  16  beats accepted in the current tile.

Function
REQ-016 Accept = in_valid && in_ready; in_ready = !abort && state != DRAIN.
REQ-017 FSM states: IDLE, FEED, DRAIN.
REQ-018 FSM transitions: IDLE->FEED on accept with !in_last; IDLE->DRAIN and FEED->DRAIN on accept with in_last; DRAIN->IDLE when drain counter reaches 0.
REQ-019 Each lane i (both sides) is a registered delay chain of exactly i+1 stages carrying {en, cm, data}.
REQ-020 A beat accepted at cycle t drives lane i outputs at cycle t+1+i, with en=1, cm=in_last and data=a_col[i] (aleft) or b_row[i] (bup).
REQ-021 Any cycle without an accept (bubble, IDLE or DRAIN) injects en=0, cm=0, data=0 into stage 0 of every lane.
REQ-022 On entry to DRAIN the drain counter loads DIM; it decrements every DRAIN cycle.
REQ-023 done pulses high in the cycle the drain counter reaches 0, which is the cycle the last beat appears on lane DIM-1.
REQ-024 The FSM returns to IDLE in the cycle after done.
REQ-025 beat_cnt clears on the IDLE->FEED/DRAIN accept, then increments per accept; it saturates at 16'hFFFF.
REQ-026 beat_cnt holds its value through DRAIN and IDLE until the next tile starts.
REQ-027 A single-beat tile (in_last on the first beat) is legal and goes IDLE->DRAIN directly.
REQ-028 abort has priority over accept: the beat is dropped, all delay stages clear to 0, FSM goes IDLE, no done pulse.
REQ-029 abort in IDLE has no effect beyond holding outputs at 0.
REQ-030 No output depends combinationally on a_col or b_row; in_ready is the only combinational output.

Reset
REQ-031 rst asserted: all delay stages, en*, cm*, aleft and bup clear to 0; FSM goes IDLE; drain counter, beat_cnt, busy and done clear to 0.
REQ-032 Reset mid-tile discards all in-flight beats; in_ready becomes 1 in the first clk edge after rst deasserts.

Structure
REQ-033 SA_DIM, DW and the FSM state enum (feed_state_t) live in package params.
REQ-034 One sub-module, skew_lane: a parameterised-depth {en, cm, data} delay chain with sync clear; it is instantiated 2*DIM times.

Verification
REQ-035 Single beat, a_col[i]=i+1, b_row[j]=16*(j+1), in_last=1 at t=0 -> aleft[i]=i+1 with enleft[i]=cmleft[i]=1 only at cycle 1+i; done at cycle 8; beat_cnt=1.
REQ-036 Eight back-to-back beats k=0..7, in_last on k=7 -> lane 3 shows k=0..7 at cycles 4..11 contiguously; done at cycle 15; cm set only on the k=7 slot.
REQ-037 Bubble: beats at t=0 and t=2 with in_valid=0 at t=1 -> lane 0 en pattern 1,0,1 at cycles 1..3, data 0 in the gap.
REQ-038 in_valid held high through DRAIN -> in_ready=0 for 8 cycles; no extra beats accepted; beat_cnt unchanged.
REQ-039 abort at cycle 3 of an 8-beat tile -> all en*=0 from cycle 4; no done pulse; FSM IDLE; next tile starts cleanly with beat_cnt=1.
REQ-040 Async rst pulse between clk edges mid-FEED -> outputs 0 immediately, before the next edge; busy=0.
